// File: rtl/acc_alu_seq.sv
// Sequenced accumulator datapath: AC/MDR registers and an ALU that runs one
// instruction per start/done handshake, with bit-serial shift and shift-add multiply.
module acc_alu_seq #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         opcode,
  input  logic [SHAMT_W-1:0] imm,
  input  logic               mdr_load,
  input  logic               ac_load,
  input  logic [WIDTH-1:0]   mdr_in,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [WIDTH-1:0]   ac_out,
  output logic [WIDTH-1:0]   mdr_out,
  output logic               zflg,
  output logic               nflg,
  output logic               cflg,
  output logic               vflg
);

  localparam int MCW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, MUL} state_t;
  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7,
    OP_SHL = 4'h8, OP_SHR = 4'h9, OP_MUL = 4'hA, OP_CLR = 4'hB
  } op_t;

  state_t               state, state_nx;
  op_t                  op_q;
  logic [SHAMT_W-1:0]   cnt;
  logic [MCW-1:0]       mcnt;
  logic [WIDTH-1:0]     ac, mdr, sh, sh_nx, mplier, res;
  logic [2*WIDTH-1:0]   prod, prod_nx, mcand;
  logic [WIDTH:0]       sum;
  logic                 sh_c, cf, vf, commit, upd, err_nx;
  logic                 sh_last, mul_last;

  assign busy    = (state != IDLE);
  assign ac_out  = ac;
  assign mdr_out = mdr;

  // imm=0 still spends one SHIFT cycle, so the last cycle is cnt of 0 or 1
  assign sh_last  = (cnt <= SHAMT_W'(1));
  assign mul_last = (mcnt == MCW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          case (op_t'(opcode))
            OP_SHL, OP_SHR: state_nx = SHIFT;
            OP_MUL:         state_nx = MUL;
            default:        state_nx = EXEC;
          endcase
        end
      end
      EXEC:    state_nx = IDLE;
      SHIFT:   if (sh_last)  state_nx = IDLE;
      MUL:     if (mul_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sh_nx = sh;
    sh_c  = 1'b0;
    if (cnt != '0) begin
      if (op_q == OP_SHL) begin
        sh_c  = sh[WIDTH-1];
        sh_nx = {sh[WIDTH-2:0], 1'b0};
      end else begin
        sh_c  = sh[0];
        sh_nx = {sh[WIDTH-1], sh[WIDTH-1:1]};
      end
    end
    prod_nx = mplier[0] ? prod + mcand : prod;
  end

  always_comb begin
    commit = 1'b0;
    upd    = 1'b0;
    err_nx = 1'b0;
    res    = ac;
    cf     = 1'b0;
    vf     = 1'b0;
    sum    = '0;
    case (state)
      EXEC: begin
        commit = 1'b1;
        upd    = 1'b1;
        case (op_q)
          OP_NOP: upd = 1'b0;
          OP_LDA: res = mdr;
          OP_ADD: begin
            sum = {1'b0, ac} + {1'b0, mdr};
            res = sum[WIDTH-1:0];
            cf  = sum[WIDTH];
            vf  = (ac[WIDTH-1] == mdr[WIDTH-1]) && (res[WIDTH-1] != ac[WIDTH-1]);
          end
          OP_SUB: begin
            sum = {1'b0, ac} - {1'b0, mdr};
            res = sum[WIDTH-1:0];
            cf  = sum[WIDTH];
            vf  = (ac[WIDTH-1] != mdr[WIDTH-1]) && (res[WIDTH-1] != ac[WIDTH-1]);
          end
          OP_AND: res = ac & mdr;
          OP_OR:  res = ac | mdr;
          OP_XOR: res = ac ^ mdr;
          OP_NOT: res = ~ac;
          OP_CLR: res = '0;
          default: begin
            upd    = 1'b0;
            err_nx = 1'b1;
          end
        endcase
      end
      SHIFT: begin
        if (sh_last) begin
          commit = 1'b1;
          upd    = 1'b1;
          res    = sh_nx;
          cf     = sh_c;
        end
      end
      MUL: begin
        if (mul_last) begin
          commit = 1'b1;
          upd    = 1'b1;
          res    = prod_nx[WIDTH-1:0];
          vf     = |prod_nx[2*WIDTH-1:WIDTH];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ac     <= '0;
      mdr    <= '0;
      op_q   <= OP_NOP;
      cnt    <= '0;
      mcnt   <= '0;
      sh     <= '0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      zflg   <= 1'b0;
      nflg   <= 1'b0;
      cflg   <= 1'b0;
      vflg   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op_t'(opcode);
            cnt    <= imm;
            sh     <= ac;
            mcnt   <= '0;
            prod   <= '0;
            mcand  <= {{WIDTH{1'b0}}, ac};
            mplier <= mdr;
          end else begin
            if (mdr_load) mdr <= mdr_in;
            if (ac_load)  ac  <= mdr_in;
          end
        end
        SHIFT: begin
          sh  <= sh_nx;
          cnt <= cnt - 1'b1;
        end
        MUL: begin
          prod   <= prod_nx;
          mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          mcnt   <= mcnt + 1'b1;
        end
        default: ;
      endcase
      if (commit) begin
        ac   <= res;
        done <= 1'b1;
        err  <= err_nx;
        if (upd) begin
          zflg <= (res == '0);
          nflg <= res[WIDTH-1];
          cflg <= cf;
          vflg <= vf;
        end
      end
    end
  end

endmodule
